// File: rtl/spdif_frame_sched.sv
// S/P DIF frame scheduler: stereo FIFO, fractional sample-rate tick, L/R word handshake.
// Build option SPDIF_SCHED_HOLD_LAST_EN: resend the last popped pair on underrun instead of silence.
module spdif_frame_sched #(
    parameter int DEPTH    = 4,
    parameter int TICK_INC = 441,
    parameter int TICK_MOD = 1000000,
    parameter int ACC_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_rdy,
    output logic [7:0]  frame_idx,
    output logic        block_start,
    output logic [7:0]  underrun_cnt,
    output logic        late_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_SEND_L, S_WAIT_L, S_SEND_R, S_WAIT_R} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_pend;
    logic             r_late;
    logic [7:0]       r_frame;
    logic [7:0]       r_und;
    logic [15:0]      r_l, r_r, r_tx_last;
    logic [15:0]      r_fifo_l [DEPTH];
    logic [15:0]      r_fifo_r [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;

    logic [ACC_W-1:0] w_sum;
    logic             w_tick, w_go, w_push, w_pop, w_strobe;
    logic [15:0]      w_und_l, w_und_r;

    assign w_sum    = r_acc + ACC_W'(TICK_INC);
    assign w_tick   = enable && (w_sum >= ACC_W'(TICK_MOD));
    assign in_ready = (r_count != CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_go     = (r_state == S_IDLE) && (w_tick || r_pend);
    assign w_pop    = w_go && (r_count != '0);

    // Strobe is combinational so it can never coincide with tx_rdy=0 and lands in SEND_L itself.
    assign w_strobe    = ((r_state == S_SEND_L) || (r_state == S_SEND_R)) && tx_rdy;
    assign tx_valid    = w_strobe;
    assign tx_data     = w_strobe ? ((r_state == S_SEND_L) ? r_l : r_r) : r_tx_last;
    assign block_start = w_strobe && (r_state == S_SEND_L) && (r_frame == 8'd0);

    assign frame_idx    = r_frame;
    assign underrun_cnt = r_und;
    assign late_err     = r_late;

`ifdef SPDIF_SCHED_HOLD_LAST_EN
    logic [15:0] r_last_l, r_last_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_pop) begin
            r_last_l <= r_fifo_l[r_rptr];
            r_last_r <= r_fifo_r[r_rptr];
        end
    end

    assign w_und_l = r_last_l;
    assign w_und_r = r_last_r;
`else
    assign w_und_l = '0;
    assign w_und_r = '0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_l[r_wptr] <= in_left;
            r_fifo_r[r_wptr] <= in_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       r_acc <= '0;
        else if (!enable) r_acc <= '0;
        else if (w_tick)  r_acc <= w_sum - ACC_W'(TICK_MOD);
        else              r_acc <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b0;
            r_late    <= 1'b0;
            r_frame   <= '0;
            r_und     <= '0;
            r_l       <= '0;
            r_r       <= '0;
            r_tx_last <= '0;
        end else begin
            // One tick may wait while busy; a second one during the same frame is lost.
            if (r_state != S_IDLE && w_tick) begin
                if (r_pend) r_late <= 1'b1;
                else        r_pend <= 1'b1;
            end
            if (w_strobe) r_tx_last <= tx_data;
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_pend <= 1'b0;
                    if (w_pop) begin
                        r_l <= r_fifo_l[r_rptr];
                        r_r <= r_fifo_r[r_rptr];
                    end else begin
                        r_l <= w_und_l;
                        r_r <= w_und_r;
                        if (r_und != 8'hFF) r_und <= r_und + 8'd1;
                    end
                    r_state <= S_SEND_L;
                end
                S_SEND_L: if (tx_rdy)  r_state <= S_WAIT_L;
                S_WAIT_L: if (!tx_rdy) r_state <= S_SEND_R;
                S_SEND_R: if (tx_rdy)  r_state <= S_WAIT_R;
                S_WAIT_R: if (!tx_rdy) begin
                    r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spdif_frame_sched.sv
// Randomized scoreboard bench for spdif_frame_sched against a frame-level reference model.
module tb_spdif_frame_sched;
    localparam int DEPTH = 4;
    localparam int INC   = 3;
    localparam int MOD   = 40;

    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, tx_rdy;
    logic [15:0] in_left, in_right;
    logic        in_ready, tx_valid, block_start, late_err;
    logic [15:0] tx_data;
    logic [7:0]  frame_idx, underrun_cnt;

    spdif_frame_sched #(.DEPTH(DEPTH), .TICK_INC(INC), .TICK_MOD(MOD), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_rdy(tx_rdy),
        .frame_idx(frame_idx), .block_start(block_start),
        .underrun_cnt(underrun_cnt), .late_err(late_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_blk = 0, n_und_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue of {L,R}; a frame is four handshake steps
    // (L accepted, rdy drop, R accepted, rdy drop); expected words queued at frame start.
    logic [31:0] m_fifo[$];
    logic [15:0] sb[$];
    int          m_acc, m_und, m_fidx, m_step;
    bit          m_pend, m_late, m_started;
    logic [15:0] m_cur_l, m_cur_r, m_last_l, m_last_r, m_txlast;

    always @(posedge clk) begin : model
        bit room, tick;
        logic [31:0] p;
        if (!rst_n) begin
            m_fifo.delete(); sb.delete();
            m_acc = 0; m_und = 0; m_fidx = 0; m_step = 0;
            m_pend = 0; m_late = 0; m_started = 1;
            m_cur_l = 0; m_cur_r = 0; m_last_l = 0; m_last_r = 0; m_txlast = 0;
        end else if (m_started) begin
            room = (m_fifo.size() != DEPTH);
            tick = enable && (m_acc + INC >= MOD);
            m_acc = !enable ? 0 : (tick ? m_acc + INC - MOD : m_acc + INC);
            if (m_step == 0) begin
                if (tick || m_pend) begin
                    m_pend = 0;
                    if (m_fifo.size() > 0) begin
                        p = m_fifo.pop_front();
                        m_cur_l = p[31:16]; m_cur_r = p[15:0];
                        m_last_l = m_cur_l; m_last_r = m_cur_r;
                    end else begin
`ifdef SPDIF_SCHED_HOLD_LAST_EN
                        m_cur_l = m_last_l; m_cur_r = m_last_r;
`else
                        m_cur_l = 16'h0; m_cur_r = 16'h0;
`endif
                        if (m_und < 255) m_und++;
                        n_und_frames++;
                    end
                    sb.push_back(m_cur_l);
                    sb.push_back(m_cur_r);
                    m_step = 1;
                end
            end else begin
                if (tick) begin
                    if (m_pend) m_late = 1;
                    else        m_pend = 1;
                end
                if ((m_step == 1 || m_step == 3) && tx_rdy) begin
                    m_txlast = (m_step == 1) ? m_cur_l : m_cur_r;
                    m_step++;
                end else if ((m_step == 2 || m_step == 4) && !tx_rdy) begin
                    if (m_step == 4) begin
                        m_step = 0;
                        m_fidx = (m_fidx + 1) % 192;
                    end else m_step = 3;
                end
            end
            if (in_valid && room) m_fifo.push_back({in_left, in_right});
        end
    end

    bit saw_strobe = 0;

    always @(negedge clk) begin : monitor
        bit ev;
        logic [15:0] d;
        if (m_started) begin
            ev = (m_step == 1 || m_step == 3) && tx_rdy;
            chk("tx_valid", tx_valid, ev);
            chk("in_ready", in_ready, m_fifo.size() != DEPTH);
            chk("frame_idx", frame_idx, m_fidx);
            chk("underrun_cnt", underrun_cnt, m_und);
            chk("late_err", late_err, m_late);
            chk("block_start", block_start, ev && m_step == 1 && m_fidx == 0);
            if (block_start) n_blk++;
            if (tx_valid) begin
                if (sb.size() == 0) chk("unexpected_word", 1, 0);
                else begin
                    d = sb.pop_front();
                    chk("tx_data", tx_data, d);
                end
            end else chk("tx_data_hold", tx_data, m_txlast);
        end
        saw_strobe = tx_valid;
    end

    // Transmitter: drops rdy the cycle after a strobe, recovers after a random delay.
    bit force_stall = 0;
    int rdy_cnt = 0;
    always begin : txbfm
        @(posedge clk); #1;
        if (force_stall) tx_rdy = 1'b0;
        else if (saw_strobe) begin
            tx_rdy  = 1'b0;
            rdy_cnt = $urandom_range(1, 4);
        end else if (!tx_rdy) begin
            if (rdy_cnt > 0) rdy_cnt--;
            if (rdy_cnt == 0) tx_rdy = 1'b1;
        end
    end

    task automatic cyc(input int n, input int push_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            in_valid = ($urandom_range(0, 99) < push_pct);
            in_left  = 16'($urandom);
            in_right = 16'($urandom);
        end
    endtask

    initial begin
        bit hit;
        rst_n = 0; enable = 0; in_valid = 0; in_left = 0; in_right = 0; tx_rdy = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        enable = 1;
        cyc(60, 0);                 // pure underrun frames
        enable = 0;
        cyc(10, 100);               // fill past DEPTH with no ticks
        in_valid = 0;
        enable = 1;
        cyc(150, 30);
        force_stall = 1;            // hold rdy low across several ticks
        cyc(60, 20);
        force_stall = 0;
        cyc(100, 20);
        for (int k = 0; k < 30; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            cyc(100, $urandom_range(0, 60));
        end
        enable = 1;
        cyc(300, 50);
        chk("block_wrap_seen", n_blk >= 2, 1);
        chk("underrun_seen", n_und_frames > 0, 1);
        hit = 0;                    // reset in the middle of the right-word phase
        for (int i = 0; i < 400 && !hit; i++) begin
            cyc(1, 50);
            hit = (m_step == 3);
        end
        chk("reach_send_r", hit, 1);
        rst_n = 0;
        @(posedge clk); #2;
        rst_n = 1;
        in_valid = 0;
        @(negedge clk);
        chk("rst_frame_idx", frame_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_tx_data", tx_data, 0);
        cyc(80, 30);
        in_valid = 0;
        cyc(40, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spdif_frame_sched.md
Name: spdif_frame_sched

Overview:
Audio frame scheduler that sits between the audio producer (SPU/CD mixer output) and the S/P DIF transmitter. Buffers stereo sample pairs in a small FIFO. Generates the sample-rate tick from the system clock with a fractional accumulator. On each tick it issues left then right 16-bit words to the transmitter over its valid/rdy handshake, tracking the 192-frame channel-status block position and counting underruns.

Parameters:
DEPTH, 4, FIFO depth in stereo pairs; power of two, minimum 2
TICK_INC, 441, accumulator increment per clk
TICK_MOD, 1000000, accumulator modulus; tick rate = f_clk*TICK_INC/TICK_MOD (44.1 kHz at 100 MHz)
ACC_W, 20, accumulator width; must hold TICK_MOD+TICK_INC-1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run tick generator
in_left  in  16  producer left sample
in_right  in  16  producer right sample
in_valid  in  1  producer pair valid
in_ready  out  1  FIFO can accept a pair
tx_data  out  16  word to transmitter
tx_valid  out  1  one-cycle word strobe to transmitter
tx_rdy  in  1  transmitter idle/ready
frame_idx  out  8  current frame within block, 0..191
block_start  out  1  pulse when frame 0 left word issued
underrun_cnt  out  8  saturating underrun count
late_err  out  1  sticky: tick dropped

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low. All state updates on posedge clk.
- Reset values: tx_data 0, tx_valid 0, frame_idx 0, block_start 0, underrun_cnt 0, late_err 0, accumulator 0, FIFO empty, pend 0, last pair 0, state IDLE. in_ready is 1 from the first cycle after reset.
- FIFO:
  - in_ready = (count != DEPTH), combinational.
  - Push when in_valid & in_ready.
  - Pop happens only in IDLE on a tick with count != 0.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Tick generator:
  - When enable=1: acc <= acc + TICK_INC. When the sum >= TICK_MOD, acc <= sum - TICK_MOD and tick=1 for that cycle.
  - When enable=0: acc <= 0 and no ticks. Any frame already in progress completes.
- Pending tick:
  - A tick arriving outside IDLE sets pend.
  - A tick arriving while pend=1 and outside IDLE is dropped and sets late_err (sticky until reset).
- FSM states:
  - IDLE: on (tick | pend), clear pend. If FIFO is non-empty, pop the pair into the L/R holding registers and the last-pair register. Otherwise this is an underrun: load the underrun pair and increment underrun_cnt, saturating at 255. Go to SEND_L.
  - SEND_L: when tx_rdy=1, drive tx_data=L and tx_valid=1 for exactly one cycle. block_start=1 in that same cycle iff frame_idx==0. Go to WAIT_L.
  - WAIT_L: wait for tx_rdy=0 (the transmitter drops rdy the cycle after the strobe), then go to SEND_R.
  - SEND_R: when tx_rdy=1, drive tx_data=R with a tx_valid pulse. Go to WAIT_R.
  - WAIT_R: on tx_rdy=0, set frame_idx <= (frame_idx==191) ? 0 : frame_idx+1 and go to IDLE.
- tx_valid is never asserted while tx_rdy=0. tx_data holds its last value when tx_valid=0.
- Latency: the first tx_valid comes 1 cycle after the tick when tx_rdy is already 1 (IDLE->SEND_L, strobe in SEND_L).
- Underrun pair: zeros, unless SPDIF_SCHED_HOLD_LAST_EN is defined.
- Reset mid-frame: the FSM returns to IDLE immediately; the FIFO contents and the partially sent frame are discarded.

Optional Feature:
SPDIF_SCHED_HOLD_LAST_EN
- Defined: on underrun, resend the last popped pair (0/0 if none has been popped since reset); the last-pair register is implemented.
- Undefined: on underrun, send 0/0; the last-pair register is omitted.
- underrun_cnt behaves identically in both builds.

Test Plan:
1. Reset, TICK_INC=1, TICK_MOD=4, enable=1, tx_rdy model (drops 1 cycle after strobe, rises 34 cycles later) -> tick every 4 clk, first tx_valid 1 clk after the first tick, underrun_cnt increments each frame with data 0/0.
2. Push pairs (0x1234,0xABCD), (0x0001,0xFFFF), then tick -> tx_data sequence 0x1234, 0xABCD, 0x0001, 0xFFFF; each strobe is 1 cycle with tx_rdy=1; underrun_cnt=0.
3. Push 4 pairs with DEPTH=4 -> in_ready=0 after the 4th push. 5th in_valid is ignored. in_ready returns to 1 the cycle after the first pop.
4. Run 193 frames -> frame_idx counts 0..191 then 0. block_start pulses on frame 0 and frame 192 left words only.
5. Hold tx_rdy=0 across 3 ticks -> pend=1 after the 2nd tick, late_err=1 after the 3rd; after tx_rdy rises the frame completes normally.
6. With SPDIF_SCHED_HOLD_LAST_EN, push (0x5555,0xAAAA), send, then underrun -> resends 0x5555/0xAAAA, underrun_cnt=1. Without the macro -> sends 0/0. Then assert rst_n=0 mid-SEND_R -> tx_valid=0, FIFO empty, frame_idx=0.
